// File: rtl/shifter_pkg.sv
// shifter_pkg: shared mode encodings, constant log2 and the stage payload for pipelined_shifter.
package shifter_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int MAX_LOG2  = 6;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // amt carries the full shift amount down the pipe; level i consumes amt[i].
    typedef struct packed {
        logic [MAX_WIDTH-1:0] data;
        logic                 fill;
        mode_t                mode;
        logic [MAX_LOG2-1:0]  amt;
        logic                 valid;
    } stage_t;

endpackage

// File: rtl/shifter_level.sv
// shifter_level: one right-shift/rotate mux level of fixed distance DIST.
// Rotate wrap path is only built when SHIFTER_ROTATE_EN is defined.
module shifter_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             fill,
    input  logic [1:0]       mode,
    input  logic             sh,
    output logic [WIDTH-1:0] dout
);

`ifdef SHIFTER_ROTATE_EN
    always_comb begin
        dout = din;
        if (sh) begin
            if (mode == MODE_ROR) dout = {din[DIST-1:0], din[WIDTH-1:DIST]};
            else                  dout = {{DIST{fill}}, din[WIDTH-1:DIST]};
        end
    end
`else
    logic unused_mode;
    assign unused_mode = ^mode;

    always_comb begin
        dout = din;
        if (sh) dout = {{DIST{fill}}, din[WIDTH-1:DIST]};
    end
`endif

endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: log2(WIDTH)-level barrel shifter, register every REG_EVERY levels, global stall.
// Define SHIFTER_ROTATE_EN to enable ROR on ctl=11; otherwise ctl=11 behaves as SRL.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam int L = clog2(WIDTH);

    logic             advance;
    logic [WIDTH-1:0] a_rev;
    stage_t           entry;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    for (genvar k = 0; k < WIDTH; k++) begin : g_in_rev
        assign a_rev[k] = A[WIDTH-1-k];
    end

    // SLL is done as a right shift on the bit-reversed operand; only SRA gets a nonzero fill.
    always_comb begin
        entry                  = '0;
        entry.valid            = in_valid;
        entry.mode             = mode_t'(ctl);
        entry.fill             = (ctl == MODE_SRA) && A[WIDTH-1];
        entry.amt[L-1:0]       = B[L-1:0];
        entry.data[WIDTH-1:0]  = (ctl == MODE_SLL) ? a_rev : A;
    end

    for (genvar i = 0; i < L; i++) begin : g_lvl
        stage_t           cur;
        stage_t           nxt;
        logic [WIDTH-1:0] shifted;

        if (i == 0) begin : g_src
            assign cur = entry;
        end else if (i % REG_EVERY == 0) begin : g_src
            assign cur = g_lvl[i-1].g_reg.q;
        end else begin : g_src
            assign cur = g_lvl[i-1].nxt;
        end

        shifter_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << i)
        ) u_level (
            .din  (cur.data[WIDTH-1:0]),
            .fill (cur.fill),
            .mode (cur.mode),
            .sh   (cur.amt[i]),
            .dout (shifted)
        );

        if (i == L-1) begin : g_out
            logic [WIDTH-1:0] shifted_rev;
            for (genvar k = 0; k < WIDTH; k++) begin : g_out_rev
                assign shifted_rev[k] = shifted[WIDTH-1-k];
            end
            always_comb begin
                nxt                  = cur;
                nxt.data             = '0;
                nxt.data[WIDTH-1:0]  = (cur.mode == MODE_SLL) ? shifted_rev : shifted;
            end
        end else begin : g_out
            always_comb begin
                nxt                  = cur;
                nxt.data             = '0;
                nxt.data[WIDTH-1:0]  = shifted;
            end
        end

        if (((i + 1) % REG_EVERY == 0) || (i == L-1)) begin : g_reg
            stage_t q;
            always_ff @(posedge clk) begin
                if (reset)        q <= '0;
                else if (advance) q <= nxt;
            end
        end
    end

    assign out       = g_lvl[L-1].g_reg.q.data[WIDTH-1:0];
    assign out_valid = g_lvl[L-1].g_reg.q.valid;

    logic unused_bits;
    assign unused_bits = ^{g_lvl[L-1].g_reg.q, B};

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: scoreboard bench for the 32-bit/REG_EVERY=1 build plus a 64-bit/REG_EVERY=6 build.
module tb_pipelined_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, out;
    logic [1:0]  ctl;

    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] A64, B64, out64;
    logic [1:0]  ctl64;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    logic [31:0] sbq[$];

    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(32), .REG_EVERY(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ctl(ctl), .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    pipelined_shifter #(.WIDTH(64), .REG_EVERY(6)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .A(A64), .B(B64), .ctl(ctl64), .out_valid(out_valid64), .out_ready(out_ready64), .out(out64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                        input logic [31:0] e);
        in_valid = 1'b1; A = a; B = b; ctl = c;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(e);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        $display("FAIL send_timeout: in_ready stuck low, got 0 expected 1");
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sbq.size() > 0; t++) @(posedge clk);
        n_checks++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending results expected 0", sbq.size());
        #1;
    endtask

    // Monitor: pops the scoreboard on every output handshake; checks hold behaviour while stalled.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !out_ready) begin
                check("in_ready_stall", {63'd0, in_ready}, 64'd0);
                if (sbq.size() > 0) check("stall_hold", {32'd0, out}, {32'd0, sbq[0]});
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got %h expected no result", out);
                end else begin
                    check("result", {32'd0, out}, {32'd0, sbq.pop_front()});
                    n_out++;
                end
            end
        end
    end

    logic [31:0] va[8], vb[8], ve[8];
    logic [1:0]  vc[8];
    logic [31:0] ror_a, ror_b, ror_c;

    initial begin
`ifdef SHIFTER_ROTATE_EN
        ror_a = 32'h80000000; ror_b = 32'h78123456; ror_c = 32'h00000003;
`else
        ror_a = 32'h00000000; ror_b = 32'h00123456; ror_c = 32'h00000001;
`endif
        va[0]=32'h00000001; vb[0]=32'd31;   vc[0]=2'b00; ve[0]=32'h80000000;
        va[1]=32'h80000000; vb[1]=32'd4;    vc[1]=2'b10; ve[1]=32'hF8000000;
        va[2]=32'h80000000; vb[2]=32'd4;    vc[2]=2'b01; ve[2]=32'h08000000;
        va[3]=32'hFFFFFFFF; vb[3]=32'h25;   vc[3]=2'b01; ve[3]=32'h07FFFFFF;
        va[4]=32'h00000001; vb[4]=32'd1;    vc[4]=2'b11; ve[4]=ror_a;
        va[5]=32'h80000001; vb[5]=32'd0;    vc[5]=2'b10; ve[5]=32'h80000001;
        va[6]=32'h12345678; vb[6]=32'd4;    vc[6]=2'b00; ve[6]=32'h23456780;
        va[7]=32'h12345678; vb[7]=32'd8;    vc[7]=2'b11; ve[7]=ror_b;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; ctl = '0;
        in_valid64 = 1'b0; out_ready64 = 1'b1; A64 = '0; B64 = '0; ctl64 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out", {32'd0, out}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid64", {63'd0, out_valid64}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Latency: first negedge after the accept edge counts as 1.
        begin
            int c;
            send(va[0], vb[0], vc[0], ve[0]);
            in_valid = 1'b0;
            c = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                c++;
                if (out_valid) break;
            end
            check("latency", c, 64'd5);
            @(posedge clk); #1;
            drain();
        end

        // Back-to-back burst with a 4-cycle output stall after the second result.
        begin
            int base;
            base = n_out;
            fork
                begin
                    for (int k = 0; k < 8; k++) send(va[k], vb[k], vc[k], ve[k]);
                    in_valid = 1'b0;
                end
                begin
                    for (int t = 0; t < 100 && n_out < base + 2; t++) @(posedge clk);
                    #1 out_ready = 1'b0;
                    repeat (4) @(posedge clk);
                    #1 out_ready = 1'b1;
                end
            join
            drain();
            check("burst_count", n_out - base, 64'd8);
        end

        send(32'h12345678, 32'd32, 2'b00, 32'h12345678);
        send(32'h87654321, 32'd16, 2'b10, 32'hFFFF8765);
        send(32'h7FFFFFFF, 32'd31, 2'b10, 32'h00000000);
        send(32'h80000001, 32'h3F, 2'b11, ror_c);
        in_valid = 1'b0;
        drain();

        // Reset with three beats in flight: they must never emerge.
        send(32'h0000000F, 32'd1, 2'b01, 32'h00000007);
        send(32'h0000000F, 32'd2, 2'b01, 32'h00000003);
        send(32'h0000000F, 32'd3, 2'b01, 32'h00000001);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        sbq.delete();
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out", {32'd0, out}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk); #1;
        send(32'h000000F0, 32'd4, 2'b00, 32'h00000F00);
        in_valid = 1'b0;
        drain();

        // 64-bit, single register stage.
        in_valid64 = 1'b1; A64 = 64'h8000000000000000; B64 = 64'd63; ctl64 = 2'b10;
        @(negedge clk);
        check("w64_in_ready", {63'd0, in_ready64}, 64'd1);
        check("w64_pre_valid", {63'd0, out_valid64}, 64'd0);
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        @(negedge clk);
        check("w64_valid", {63'd0, out_valid64}, 64'd1);
        check("w64_sra", out64, 64'hFFFFFFFFFFFFFFFF);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined barrel shifter for the vALU datapath: shifts or rotates a WIDTH-bit operand by the low log2(WIDTH) bits of a shift-amount operand. Built as log2(WIDTH) binary mux levels (1, 2, 4, … WIDTH/2) between optional bit-reversal stages, with pipeline registers inserted every REG_EVERY levels. A valid/ready handshake on both sides lets it sit between the operand-issue logic and the ALU result mux under backpressure, at one operation per cycle.

## Interface
- WIDTH, 32, operand width; power of two, 8..64
- REG_EVERY, 1, mux levels per pipeline register; 1..log2(WIDTH)
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts beat this cycle
- A  input  WIDTH  operand to shift
- B  input  WIDTH  shift amount; only B[log2(WIDTH)-1:0] used
- ctl  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  shifted result

## Operation
- Levels: L = log2(WIDTH); latency LAT = ceil(L / REG_EVERY) register stages.
- SLL: A bit-reversed on entry, right-shifted zero-fill, result bit-reversed on exit.
- SRL: right shift, zero-fill. SRA: right shift, fill with A[WIDTH-1] captured at entry and carried down the pipe.
- ROR: bits shifted out of bit 0 re-enter at bit WIDTH-1 at every level.
- Amount is B modulo WIDTH; amount 0 returns A unchanged in every mode.
- Each pipeline stage holds data, fill bit, mode, level progress and a valid bit; mode and sign travel with the data.
- Global stall: advance = out_ready | ~out_valid. When advance is 0 every stage holds. in_ready = advance (combinational from out_ready and out_valid only, never from in_valid).
- Beat accepted when in_valid & in_ready; bubbles (in_valid=0 while advancing) propagate as valid=0 stages.
- out and out_valid are driven directly from the last stage register; out stable while out_valid & ~out_ready.

## Timing
- Reset: all stage valid bits 0, all data registers 0; out_valid=0, out=0; in_ready=1 during and after reset (out_valid is 0).
- Beat accepted at edge n appears with out_valid=1 at edge n+LAT (no stall).
- Throughput: one result per cycle with out_ready held 1.
- Stall: out_ready=0 with out_valid=1 freezes the whole pipe; in_ready=0 same cycle; no beat lost or duplicated.
- Simultaneous out accept and in accept: both occur; pipe shifts one position.
- Reset mid-operation: all in-flight beats discarded; first accepted beat after reset is the first result.
- REG_EVERY = L: single register stage, LAT = 1.

## Configuration
- SHIFTER_ROTATE_EN defined: ctl=11 performs ROR as above.
- Not defined: rotate wrap paths not built; ctl=11 behaves exactly as SRL (zero-fill right shift).

## Structure
- Package shifter_pkg: mode encodings (MODE_SLL=2'b00, MODE_SRL=2'b01, MODE_SRA=2'b10, MODE_ROR=2'b11), log2 constant function, stage payload typedef (data, fill, mode, valid).
- One sub-module: shifter_level — a single mux level of configurable distance, taking data, fill bit, mode and one amount bit; instantiated L times by generate, registers inserted between groups of REG_EVERY instances in the top level.

## Test plan
WIDTH=32, REG_EVERY=1 (LAT=5) unless noted.
- SLL A=0x00000001, B=31 -> out=0x80000000 with out_valid exactly 5 cycles after accept.
- SRA A=0x80000000, B=4 -> 0xF8000000; SRL same operands -> 0x08000000; B=0x25 (low bits 5) SRL A=0xFFFFFFFF -> 0x07FFFFFF.
- ROR A=0x00000001, B=1 -> 0x80000000 with SHIFTER_ROTATE_EN; 0x00000000 without.
- Back-to-back 8 beats, out_ready=0 for cycles 3..6 -> in_ready low those cycles, all 8 results in order, none dropped or repeated, out stable while stalled.
- Reset asserted with 3 beats in flight -> out_valid=0, out=0 next cycle; no stale result ever emitted.
- WIDTH=64, REG_EVERY=6: SRA A=0x8000000000000000, B=63 -> 0xFFFFFFFFFFFFFFFF after LAT=1.
